// File: rtl/rob_retire_pkg.sv
// Shared types and sizing for the in-order retirement unit (ROB) and its interface.
package rob_retire_pkg;

   localparam int ROB_DEPTH         = 16;
   localparam int NUM_ALLOC_PRTS    = 2;
   localparam int NUM_CPL_PRTS      = 4;
   localparam int PR_FREE_PRTS      = 2;
   localparam int NUM_PHYSICAL_REGS = 64;
   localparam int NUM_ISA_REGS      = 19;

   localparam int PRW = $clog2(NUM_PHYSICAL_REGS);
   localparam int ARW = $clog2(NUM_ISA_REGS);
   localparam int IW  = $clog2(ROB_DEPTH);
   localparam int CW  = $clog2(ROB_DEPTH + 1);

   typedef logic [IW-1:0] rob_idx_t;
   typedef logic [CW-1:0] rob_cnt_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } rob_state_t;

   typedef struct packed {
      logic           valid;
      logic           complete;
      logic           dst;
      logic [ARW-1:0] arch;
      logic [PRW-1:0] npr;
      logic [PRW-1:0] opr;
   } rob_entry;

endpackage

// File: rtl/rob_retire_if.sv
// Rename/execute/scoreboard-facing signal bundle of the ROB; master drives alloc/completion/flush.
interface rob_retire_if;
   import rob_retire_pkg::*;

   logic [NUM_ALLOC_PRTS-1:0]          rob_alloc;
   logic [NUM_ALLOC_PRTS-1:0]          rob_alloc_dst;
   logic [NUM_ALLOC_PRTS-1:0][ARW-1:0] rob_alloc_arch;
   logic [NUM_ALLOC_PRTS-1:0][PRW-1:0] rob_alloc_npr;
   logic [NUM_ALLOC_PRTS-1:0][PRW-1:0] rob_alloc_opr;
   logic [NUM_ALLOC_PRTS-1:0][IW-1:0]  rob_alloc_idx;
   logic [CW-1:0]                      rob_free_slots;
   logic [NUM_CPL_PRTS-1:0]            cpl_v;
   logic [NUM_CPL_PRTS-1:0][IW-1:0]    cpl_idx;
   logic [PR_FREE_PRTS-1:0]            free_pr;
   logic [PR_FREE_PRTS-1:0][PRW-1:0]   pr_to_free;
   logic [PR_FREE_PRTS-1:0]            ratc_we;
   logic [PR_FREE_PRTS-1:0][ARW-1:0]   ratc_arch;
   logic [PR_FREE_PRTS-1:0][PRW-1:0]   ratc_pr;
   logic                               flush;
   logic                               flushing;

   modport master (
      output rob_alloc, rob_alloc_dst, rob_alloc_arch, rob_alloc_npr, rob_alloc_opr,
      output cpl_v, cpl_idx, flush,
      input  rob_alloc_idx, rob_free_slots, free_pr, pr_to_free,
      input  ratc_we, ratc_arch, ratc_pr, flushing
   );

   modport slave (
      input  rob_alloc, rob_alloc_dst, rob_alloc_arch, rob_alloc_npr, rob_alloc_opr,
      input  cpl_v, cpl_idx, flush,
      output rob_alloc_idx, rob_free_slots, free_pr, pr_to_free,
      output ratc_we, ratc_arch, ratc_pr, flushing
   );

endinterface

// File: rtl/rob_retire.sv
// In-order retirement unit: allocates in program order, retires up to PR_FREE_PRTS complete entries
// per cycle into the commit RAT / PR scoreboard, and walks youngest-first on flush to free new PRs.
module rob_retire
   import rob_retire_pkg::*;
(
   input logic         clk,
   input logic         rst,
   rob_retire_if.slave rob
);

   rob_entry   entries   [ROB_DEPTH];
   rob_entry   entries_n [ROB_DEPTH];
   rob_idx_t   head, head_n, tail, tail_n, walk, walk_n;
   rob_cnt_t   count, count_n, free_slots, free_slots_n;
   rob_state_t state, state_n;

   logic [PR_FREE_PRTS-1:0]          free_pr_q, free_pr_n;
   logic [PR_FREE_PRTS-1:0][PRW-1:0] pr_to_free_q, pr_to_free_n;
   logic [PR_FREE_PRTS-1:0]          ratc_we_q, ratc_we_n;
   logic [PR_FREE_PRTS-1:0][ARW-1:0] ratc_arch_q, ratc_arch_n;
   logic [PR_FREE_PRTS-1:0][PRW-1:0] ratc_pr_q, ratc_pr_n;
   logic                             flushing_q, flushing_n;

   logic     go;
   rob_cnt_t n_alloc, n_ret;
   rob_idx_t slot, alloc_slot;
   rob_entry e;

   // Lane k's slot counts only the asserted lanes below it.
   always_comb begin
      alloc_slot = tail;
      for (int unsigned k = 0; k < NUM_ALLOC_PRTS; k++) begin
         rob.rob_alloc_idx[k] = alloc_slot;
         if (rob.rob_alloc[k]) alloc_slot = alloc_slot + rob_idx_t'(1);
      end
   end

   always_comb begin
      entries_n    = entries;
      head_n       = head;
      tail_n       = tail;
      walk_n       = walk;
      count_n      = count;
      free_slots_n = free_slots;
      state_n      = state;
      free_pr_n    = '0;
      pr_to_free_n = '0;
      ratc_we_n    = '0;
      ratc_arch_n  = '0;
      ratc_pr_n    = '0;
      go           = 1'b1;
      n_alloc      = '0;
      n_ret        = '0;
      slot         = '0;
      e            = '0;

      case (state)
         RUN: begin
            if (rob.flush) begin
               state_n      = FLUSH;
               walk_n       = tail - rob_idx_t'(1);
               free_slots_n = '0;
            end else begin
               for (int unsigned c = 0; c < NUM_CPL_PRTS; c++) begin
                  if (rob.cpl_v[c] && entries[rob.cpl_idx[c]].valid)
                     entries_n[rob.cpl_idx[c]].complete = 1'b1;
               end

               // Retire judges pre-edge completion, giving the one-edge completion-to-retire latency.
               for (int unsigned k = 0; k < PR_FREE_PRTS; k++) begin
                  slot = head + rob_idx_t'(k);
                  e    = entries[slot];
                  if (go && e.valid && e.complete) begin
                     n_ret                    = n_ret + rob_cnt_t'(1);
                     entries_n[slot].valid    = 1'b0;
                     entries_n[slot].complete = 1'b0;
                     if (e.dst) begin
                        free_pr_n[k]    = 1'b1;
                        pr_to_free_n[k] = e.opr;
                        ratc_we_n[k]    = 1'b1;
                        ratc_arch_n[k]  = e.arch;
                        ratc_pr_n[k]    = e.npr;
                     end
                  end else begin
                     go = 1'b0;
                  end
               end

               for (int unsigned k = 0; k < NUM_ALLOC_PRTS; k++) begin
                  if (rob.rob_alloc[k]) begin
                     entries_n[rob.rob_alloc_idx[k]] = '{
                        valid:    1'b1,
                        complete: 1'b0,
                        dst:      rob.rob_alloc_dst[k],
                        arch:     rob.rob_alloc_arch[k],
                        npr:      rob.rob_alloc_npr[k],
                        opr:      rob.rob_alloc_opr[k]
                     };
                     n_alloc = n_alloc + rob_cnt_t'(1);
                  end
               end

               tail_n       = tail + rob_idx_t'(n_alloc);
               head_n       = head + rob_idx_t'(n_ret);
               count_n      = count + n_alloc - n_ret;
               free_slots_n = rob_cnt_t'(ROB_DEPTH) - count_n;
            end
         end

         FLUSH: begin
            // count doubles as the number of entries still to be walked.
            for (int unsigned k = 0; k < PR_FREE_PRTS; k++) begin
               if (rob_cnt_t'(k) < count) begin
                  slot            = walk - rob_idx_t'(k);
                  e               = entries[slot];
                  free_pr_n[k]    = e.dst;
                  pr_to_free_n[k] = e.dst ? e.npr : '0;
                  entries_n[slot] = '0;
               end
            end
            if (count <= rob_cnt_t'(PR_FREE_PRTS)) begin
               tail_n       = head;
               count_n      = '0;
               state_n      = RUN;
               free_slots_n = rob_cnt_t'(ROB_DEPTH);
            end else begin
               walk_n  = walk - rob_idx_t'(PR_FREE_PRTS);
               count_n = count - rob_cnt_t'(PR_FREE_PRTS);
            end
         end

         default: state_n = RUN;
      endcase

      flushing_n = (state_n == FLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         head         <= '0;
         tail         <= '0;
         walk         <= '0;
         count        <= '0;
         free_slots   <= rob_cnt_t'(ROB_DEPTH);
         free_pr_q    <= '0;
         pr_to_free_q <= '0;
         ratc_we_q    <= '0;
         ratc_arch_q  <= '0;
         ratc_pr_q    <= '0;
         flushing_q   <= 1'b0;
         for (int unsigned i = 0; i < ROB_DEPTH; i++) entries[i] <= '0;
      end else begin
         state        <= state_n;
         head         <= head_n;
         tail         <= tail_n;
         walk         <= walk_n;
         count        <= count_n;
         free_slots   <= free_slots_n;
         free_pr_q    <= free_pr_n;
         pr_to_free_q <= pr_to_free_n;
         ratc_we_q    <= ratc_we_n;
         ratc_arch_q  <= ratc_arch_n;
         ratc_pr_q    <= ratc_pr_n;
         flushing_q   <= flushing_n;
         entries      <= entries_n;
      end
   end

   assign rob.rob_free_slots = free_slots;
   assign rob.free_pr        = free_pr_q;
   assign rob.pr_to_free     = pr_to_free_q;
   assign rob.ratc_we        = ratc_we_q;
   assign rob.ratc_arch      = ratc_arch_q;
   assign rob.ratc_pr        = ratc_pr_q;
   assign rob.flushing       = flushing_q;

   alloc_within_free_slots: assert property (
      @(posedge clk) disable iff (rst)
      rob_cnt_t'($countones(rob.rob_alloc)) <= free_slots
   ) else $error("rob_retire: allocation exceeds rob_free_slots");

endmodule
